// File: rtl/oc8051_tc_pkg.sv
// Shared constants, types and the per-timer count step for the 8051 timer/counter block.
package oc8051_tc_pkg;

  localparam logic [7:0] OC8051_SFR_TMOD = 8'h89;
  localparam logic [7:0] OC8051_SFR_TL0  = 8'h8A;
  localparam logic [7:0] OC8051_SFR_TL1  = 8'h8B;
  localparam logic [7:0] OC8051_SFR_TH0  = 8'h8C;
  localparam logic [7:0] OC8051_SFR_TH1  = 8'h8D;

  localparam logic [7:0] OC8051_RST_TMOD = 8'h00;
  localparam logic [7:0] OC8051_RST_TH   = 8'h00;
  localparam logic [7:0] OC8051_RST_TL   = 8'h00;

  typedef enum logic [1:0] {
    OC8051_TMOD_M13    = 2'd0,
    OC8051_TMOD_M16    = 2'd1,
    OC8051_TMOD_M8R    = 2'd2,
    OC8051_TMOD_MSPLIT = 2'd3
  } tc_mode_e;

  // Overflow is attributed to the byte that produced it so a colliding write can cancel it.
  typedef struct packed {
    logic [7:0] th;
    logic [7:0] tl;
    logic       ovf_tl;
    logic       ovf_th;
  } tc_cnt_t;

  // In split mode only the TL half is stepped here; the caller handles TH.
  function automatic tc_cnt_t tc_count(input tc_mode_e mode, input logic [7:0] th,
                                       input logic [7:0] tl, input logic tick);
    tc_cnt_t r;
    logic    carry;
    r.th     = th;
    r.tl     = tl;
    r.ovf_tl = 1'b0;
    r.ovf_th = 1'b0;
    carry    = 1'b0;
    case (mode)
      OC8051_TMOD_M13: begin
        carry    = tick & (tl[4:0] == 5'h1F);
        r.tl     = {tl[7:5], tl[4:0] + {4'd0, tick}};
        r.th     = th + {7'd0, carry};
        r.ovf_th = carry & (th == 8'hFF);
      end
      OC8051_TMOD_M16: begin
        carry    = tick & (tl == 8'hFF);
        r.tl     = tl + {7'd0, tick};
        r.th     = th + {7'd0, carry};
        r.ovf_th = carry & (th == 8'hFF);
      end
      OC8051_TMOD_M8R: begin
        if (tick) begin
          if (tl == 8'hFF) begin
            r.tl     = th;
            r.ovf_tl = 1'b1;
          end else begin
            r.tl = tl + 8'd1;
          end
        end
      end
      default: begin
        r.tl     = tl + {7'd0, tick};
        r.ovf_tl = tick & (tl == 8'hFF);
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/oc8051_tc_if.sv
// SFR byte bus between the core and the timer/counter block.
interface oc8051_tc_if;
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       wr;
  logic       wr_bit;

  modport master (output wr_addr, rd_addr, data_in, wr, wr_bit, input data_out);
  modport slave  (input wr_addr, rd_addr, data_in, wr, wr_bit, output data_out);
endinterface

// File: rtl/oc8051_tc_sync.sv
// Pin synchronizer (CNT_SYNC flops, legal 1..3) with falling-edge detect on the synced level.
module oc8051_tc_sync #(
  parameter int CNT_SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic fall
);

  logic [CNT_SYNC-1:0] sync_q, sync_d;
  logic                prev_q, prev_d;

  always_comb begin
    sync_d[0] = pin;
    for (int i = 1; i < CNT_SYNC; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync_q[CNT_SYNC-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q[CNT_SYNC-1];
  assign fall = prev_q & ~sync_q[CNT_SYNC-1];

endmodule

// File: rtl/oc8051_tc.sv
// 8051 timer/counter 0 and 1: TMOD/THx/TLx SFRs, mode 0..3 counting and overflow pulses.
module oc8051_tc
  import oc8051_tc_pkg::*;
#(
  parameter int CNT_SYNC = 2
) (
  input  logic           clk,
  input  logic           rst,
  oc8051_tc_if.slave     sfr,
  input  logic           tr0,
  input  logic           tr1,
  input  logic           t0,
  input  logic           t1,
  input  logic           int0,
  input  logic           int1,
  output logic           tf0,
  output logic           tf1
);

  logic [3:0] pin_raw, pin_sync, pin_fall;
  logic [3:0] unused_pins;

  assign pin_raw     = {int1, int0, t1, t0};
  assign unused_pins = {pin_fall[3:2], pin_sync[1:0]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      oc8051_tc_sync #(.CNT_SYNC(CNT_SYNC)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (pin_raw[gi]),
        .sync (pin_sync[gi]),
        .fall (pin_fall[gi])
      );
    end
  endgenerate

  logic [7:0] tmod_q, tmod_d, tl0_q, tl0_d, th0_q, th0_d, tl1_q, tl1_d, th1_q, th1_d;
  logic [7:0] data_out_q, data_out_d;
  logic       tf0_q, tf0_d, tf1_q, tf1_d;

  logic       wr_en, wr_tmod, wr_tl0, wr_th0, wr_tl1, wr_th1;
  tc_mode_e   mode0, mode1;
  logic       split, run0, run1, tick0, tick1, ovf_th0, ovf0, ovf1, rd_hit;
  tc_cnt_t    cnt0, cnt1;
  logic [7:0] th0_cnt, rd_val;

  always_comb begin
    wr_en   = sfr.wr & ~sfr.wr_bit;
    wr_tmod = wr_en & (sfr.wr_addr == OC8051_SFR_TMOD);
    wr_tl0  = wr_en & (sfr.wr_addr == OC8051_SFR_TL0);
    wr_th0  = wr_en & (sfr.wr_addr == OC8051_SFR_TH0);
    wr_tl1  = wr_en & (sfr.wr_addr == OC8051_SFR_TL1);
    wr_th1  = wr_en & (sfr.wr_addr == OC8051_SFR_TH1);

    mode0 = tc_mode_e'(tmod_q[1:0]);
    mode1 = tc_mode_e'(tmod_q[5:4]);
    split = (mode0 == OC8051_TMOD_MSPLIT);

    run0  = tr0 & (~tmod_q[3] | pin_sync[2]);
    run1  = tr1 & (~tmod_q[7] | pin_sync[3]);
    tick0 = run0 & (~tmod_q[2] | pin_fall[0]);
    // Timer 1 stops while timer 0 is split because TH0 has taken over tr1.
    tick1 = run1 & (~tmod_q[6] | pin_fall[1]) & ~split & (mode1 != OC8051_TMOD_MSPLIT);

    cnt0 = tc_count(mode0, th0_q, tl0_q, tick0);
    cnt1 = tc_count(mode1, th1_q, tl1_q, tick1);

    th0_cnt = split ? th0_q + {7'd0, tr1} : cnt0.th;
    ovf_th0 = split ? (tr1 & (th0_q == 8'hFF)) : cnt0.ovf_th;

    tmod_d = wr_tmod ? sfr.data_in : tmod_q;
    tl0_d  = wr_tl0  ? sfr.data_in : cnt0.tl;
    th0_d  = wr_th0  ? sfr.data_in : th0_cnt;
    tl1_d  = wr_tl1  ? sfr.data_in : cnt1.tl;
    th1_d  = wr_th1  ? sfr.data_in : cnt1.th;

    ovf0 = (cnt0.ovf_tl & ~wr_tl0) | (~split & ovf_th0 & ~wr_th0);
    ovf1 = split ? (ovf_th0 & ~wr_th0)
                 : ((cnt1.ovf_tl & ~wr_tl1) | (cnt1.ovf_th & ~wr_th1));
    // A pulse is always followed by a low cycle so the edge detector downstream sees every one.
    tf0_d = ovf0 & ~tf0_q;
    tf1_d = ovf1 & ~tf1_q;

    rd_hit = 1'b1;
    rd_val = 8'h00;
    case (sfr.rd_addr)
      OC8051_SFR_TMOD: rd_val = tmod_q;
      OC8051_SFR_TL0:  rd_val = tl0_q;
      OC8051_SFR_TH0:  rd_val = th0_q;
      OC8051_SFR_TL1:  rd_val = tl1_q;
      OC8051_SFR_TH1:  rd_val = th1_q;
      default:         rd_hit = 1'b0;
    endcase
    data_out_d = (rd_hit & wr_en & (sfr.wr_addr == sfr.rd_addr)) ? sfr.data_in : rd_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmod_q     <= OC8051_RST_TMOD;
      tl0_q      <= OC8051_RST_TL;
      th0_q      <= OC8051_RST_TH;
      tl1_q      <= OC8051_RST_TL;
      th1_q      <= OC8051_RST_TH;
      data_out_q <= 8'h00;
      tf0_q      <= 1'b0;
      tf1_q      <= 1'b0;
    end else begin
      tmod_q     <= tmod_d;
      tl0_q      <= tl0_d;
      th0_q      <= th0_d;
      tl1_q      <= tl1_d;
      th1_q      <= th1_d;
      data_out_q <= data_out_d;
      tf0_q      <= tf0_d;
      tf1_q      <= tf1_d;
    end
  end

  assign sfr.data_out = data_out_q;
  assign tf0          = tf0_q;
  assign tf1          = tf1_q;

endmodule
